// File: rtl/mem_req_arbiter.sv
// Two-to-one memory request arbiter: data has fixed priority over instruction fetch,
// grants lock until accepted, and an in-order tag FIFO steers responses back.
module mem_req_arbiter #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        m_req,
  output logic        m_wr,
  output logic [1:0]  m_size,
  output logic [31:0] m_addr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_wdata,
  input  logic        m_addr_ok,
  input  logic        m_data_ok,
  input  logic [31:0] m_rdata
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_INST = 2'd1,
    SRC_DATA = 2'd2
  } src_t;

  src_t             r_grant;
  src_t             w_grant_nxt;
  src_t             w_sel;
  logic [DEPTH-1:0] r_tags;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_can_issue;
  logic             w_issue;
  logic             w_push;
  logic             w_pop;
  logic             w_head;

  // A locked grant always wins; a fresh choice needs a free tag slot.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    w_sel       = SRC_NONE;
    w_can_issue = (r_count < CW'(DEPTH));
    if (r_grant != SRC_NONE) begin
      w_sel = r_grant;
    end else if (w_can_issue) begin
      if (data_req) begin
        w_sel = SRC_DATA;
      end else if (inst_req) begin
        w_sel = SRC_INST;
      end
    end
  end

  assign w_issue = (w_sel != SRC_NONE);
  assign w_push  = w_issue & m_addr_ok;
  assign w_pop   = m_data_ok & (r_count != '0);
  assign w_head  = r_tags[r_rd_ptr];

  always_comb begin
    w_grant_nxt = r_grant;
    if (w_issue) begin
      w_grant_nxt = m_addr_ok ? SRC_NONE : w_sel;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      r_grant <= SRC_NONE;
    end else begin
      r_grant <= w_grant_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: tag storage is not reset; validity is defined solely by the count and pointers.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_tags[r_wr_ptr] <= (w_sel == SRC_DATA);
    end
  end

  // Downstream fields follow the selected source; everything is held at zero during reset.
  always_comb begin
    m_req   = 1'b0;
    m_wr    = 1'b0;
    m_size  = 2'd0;
    m_addr  = 32'd0;
    m_wstrb = 4'd0;
    m_wdata = 32'd0;
    if (!reset) begin
      m_req = w_issue;
      case (w_sel)
        SRC_DATA: begin
          m_wr    = data_wr;
          m_size  = data_size;
          m_addr  = data_addr;
          m_wstrb = data_wstrb;
          m_wdata = data_wdata;
        end
        SRC_INST: begin
          m_size = inst_size;
          m_addr = inst_addr;
        end
        default: ;
      endcase
    end
  end

  assign inst_addr_ok = ~reset & m_addr_ok & (w_sel == SRC_INST);
  assign data_addr_ok = ~reset & m_addr_ok & (w_sel == SRC_DATA);
  assign inst_data_ok = ~reset & w_pop & ~w_head;
  assign data_data_ok = ~reset & w_pop & w_head;
  assign inst_rdata   = reset ? 32'd0 : m_rdata;
  assign data_rdata   = reset ? 32'd0 : m_rdata;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: a DEPTH=2 and a DEPTH=4 instance share stimulus,
// and each scenario checks whichever instance it targets.
module tb_mem_req_arbiter;

  logic        clk;
  logic        reset;
  logic        inst_req;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_wdata;
  logic        m_addr_ok;
  logic        m_data_ok;
  logic [31:0] m_rdata;

  logic        a2_inst_addr_ok, a2_inst_data_ok, a2_data_addr_ok, a2_data_data_ok;
  logic [31:0] a2_inst_rdata, a2_data_rdata;
  logic        a2_m_req, a2_m_wr;
  logic [1:0]  a2_m_size;
  logic [31:0] a2_m_addr, a2_m_wdata;
  logic [3:0]  a2_m_wstrb;

  logic        a4_inst_addr_ok, a4_inst_data_ok, a4_data_addr_ok, a4_data_data_ok;
  logic [31:0] a4_inst_rdata, a4_data_rdata;
  logic        a4_m_req, a4_m_wr;
  logic [1:0]  a4_m_size;
  logic [31:0] a4_m_addr, a4_m_wdata;
  logic [3:0]  a4_m_wstrb;

  int n_checks;
  int n_errors;

  mem_req_arbiter #(.DEPTH(2)) u_arb2 (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(a2_inst_addr_ok), .inst_data_ok(a2_inst_data_ok), .inst_rdata(a2_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(a2_data_addr_ok), .data_data_ok(a2_data_data_ok), .data_rdata(a2_data_rdata),
    .m_req(a2_m_req), .m_wr(a2_m_wr), .m_size(a2_m_size), .m_addr(a2_m_addr),
    .m_wstrb(a2_m_wstrb), .m_wdata(a2_m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  mem_req_arbiter #(.DEPTH(4)) u_arb4 (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_addr_ok(a4_inst_addr_ok), .inst_data_ok(a4_inst_data_ok), .inst_rdata(a4_inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata),
    .data_addr_ok(a4_data_addr_ok), .data_data_ok(a4_data_data_ok), .data_rdata(a4_data_rdata),
    .m_req(a4_m_req), .m_wr(a4_m_wr), .m_size(a4_m_size), .m_addr(a4_m_addr),
    .m_wstrb(a4_m_wstrb), .m_wdata(a4_m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    inst_req   = 1'b0;
    inst_size  = 2'd2;
    inst_addr  = 32'd0;
    data_req   = 1'b0;
    data_wr    = 1'b0;
    data_size  = 2'd2;
    data_addr  = 32'd0;
    data_wstrb = 4'd0;
    data_wdata = 32'd0;
    m_addr_ok  = 1'b0;
    m_data_ok  = 1'b0;
    m_rdata    = 32'd0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    reset = 1'b1;

    // Reset: outputs forced low even with live requests and responses present
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h1C00_0000; m_addr_ok = 1'b1;
    m_data_ok = 1'b1; m_rdata = 32'hFFFF_FFFF;
    #1;
    check("rst_m_req",        a2_m_req,        32'd0);
    check("rst_m_addr",       a2_m_addr,       32'd0);
    check("rst_inst_addr_ok", a2_inst_addr_ok, 32'd0);
    check("rst_inst_data_ok", a2_inst_data_ok, 32'd0);
    check("rst_inst_rdata",   a2_inst_rdata,   32'd0);

    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    #1;
    check("idle_m_req",        a2_m_req,        32'd0);
    check("idle_inst_addr_ok", a2_inst_addr_ok, 32'd0);
    check("idle_data_addr_ok", a2_data_addr_ok, 32'd0);
    check("idle_inst_data_ok", a2_inst_data_ok, 32'd0);
    check("idle_data_data_ok", a2_data_data_ok, 32'd0);

    // Single fetch
    @(negedge clk);
    inst_req = 1'b1; inst_addr = 32'h1C00_0000; m_addr_ok = 1'b1;
    #1;
    check("fetch_m_req",        a2_m_req,        32'd1);
    check("fetch_m_addr",       a2_m_addr,       32'h1C00_0000);
    check("fetch_m_wr",         a2_m_wr,         32'd0);
    check("fetch_m_size",       a2_m_size,       32'd2);
    check("fetch_inst_addr_ok", a2_inst_addr_ok, 32'd1);
    check("fetch_data_addr_ok", a2_data_addr_ok, 32'd0);
    @(negedge clk);
    clear_inputs();
    m_data_ok = 1'b1; m_rdata = 32'h1234_5678;
    #1;
    check("fetch_inst_data_ok", a2_inst_data_ok, 32'd1);
    check("fetch_inst_rdata",   a2_inst_rdata,   32'h1234_5678);
    check("fetch_data_data_ok", a2_data_data_ok, 32'd0);

    // Priority: store beats fetch, responses route data then inst
    @(negedge clk);
    clear_inputs();
    inst_req = 1'b1; inst_addr = 32'h0000_2000;
    data_req = 1'b1; data_wr = 1'b1; data_addr = 32'h0000_0100;
    data_wstrb = 4'hF; data_wdata = 32'hDEAD_BEEF; m_addr_ok = 1'b1;
    #1;
    check("pri_m_wr",         a2_m_wr,         32'd1);
    check("pri_m_addr",       a2_m_addr,       32'h0000_0100);
    check("pri_m_wstrb",      a2_m_wstrb,      32'hF);
    check("pri_m_wdata",      a2_m_wdata,      32'hDEAD_BEEF);
    check("pri_data_addr_ok", a2_data_addr_ok, 32'd1);
    check("pri_inst_addr_ok", a2_inst_addr_ok, 32'd0);
    @(negedge clk);
    data_req = 1'b0;
    #1;
    check("pri2_m_addr",       a2_m_addr,       32'h0000_2000);
    check("pri2_m_wr",         a2_m_wr,         32'd0);
    check("pri2_m_wstrb",      a2_m_wstrb,      32'd0);
    check("pri2_m_wdata",      a2_m_wdata,      32'd0);
    check("pri2_inst_addr_ok", a2_inst_addr_ok, 32'd1);
    @(negedge clk);
    clear_inputs();
    m_data_ok = 1'b1; m_rdata = 32'h0000_AAAA;
    #1;
    check("pri_rsp1_data_ok", a2_data_data_ok, 32'd1);
    check("pri_rsp1_inst_ok", a2_inst_data_ok, 32'd0);
    check("pri_rsp1_rdata",   a2_data_rdata,   32'h0000_AAAA);
    @(negedge clk);
    m_rdata = 32'h0000_BBBB;
    #1;
    check("pri_rsp2_inst_ok", a2_inst_data_ok, 32'd1);
    check("pri_rsp2_data_ok", a2_data_data_ok, 32'd0);

    // Lock: a stalled fetch keeps the port even when data arrives
    @(negedge clk);
    clear_inputs();
    inst_req = 1'b1; inst_addr = 32'h0000_3000;
    #1;
    check("lock0_m_req",   a2_m_req,        32'd1);
    check("lock0_m_addr",  a2_m_addr,       32'h0000_3000);
    check("lock0_inst_ok", a2_inst_addr_ok, 32'd0);
    @(negedge clk);
    data_req = 1'b1; data_addr = 32'h0000_0400;
    #1;
    check("lock1_m_addr",  a2_m_addr,       32'h0000_3000);
    check("lock1_data_ok", a2_data_addr_ok, 32'd0);
    @(negedge clk);
    #1;
    check("lock2_m_addr",  a2_m_addr,       32'h0000_3000);
    check("lock2_m_wr",    a2_m_wr,         32'd0);
    @(negedge clk);
    m_addr_ok = 1'b1;
    #1;
    check("lock3_m_addr",  a2_m_addr,       32'h0000_3000);
    check("lock3_inst_ok", a2_inst_addr_ok, 32'd1);
    check("lock3_data_ok", a2_data_addr_ok, 32'd0);
    @(negedge clk);
    inst_req = 1'b0;
    #1;
    check("lock4_m_addr",  a2_m_addr,       32'h0000_0400);
    check("lock4_data_ok", a2_data_addr_ok, 32'd1);
    @(negedge clk);
    clear_inputs();
    m_data_ok = 1'b1; m_rdata = 32'h0000_0011;
    #1;
    check("lock_rsp1_inst_ok", a2_inst_data_ok, 32'd1);
    @(negedge clk);
    m_rdata = 32'h0000_0022;
    #1;
    check("lock_rsp2_data_ok", a2_data_data_ok, 32'd1);
    check("lock_rsp2_inst_ok", a2_inst_data_ok, 32'd0);

    // Full (DEPTH=2): third request blocked until the cycle after a pop
    @(negedge clk);
    clear_inputs();
    data_req = 1'b1; data_addr = 32'h0000_0500; m_addr_ok = 1'b1;
    #1;
    check("full0_data_ok", a2_data_addr_ok, 32'd1);
    @(negedge clk);
    data_addr = 32'h0000_0504;
    #1;
    check("full1_data_ok", a2_data_addr_ok, 32'd1);
    @(negedge clk);
    data_addr = 32'h0000_0508;
    #1;
    check("full2_m_req",   a2_m_req,        32'd0);
    check("full2_data_ok", a2_data_addr_ok, 32'd0);
    @(negedge clk);
    m_data_ok = 1'b1; m_rdata = 32'h0000_0005;
    #1;
    check("full3_m_req",     a2_m_req,        32'd0);
    check("full3_data_dok",  a2_data_data_ok, 32'd1);
    @(negedge clk);
    m_data_ok = 1'b0;
    #1;
    check("full4_m_req",   a2_m_req,        32'd1);
    check("full4_m_addr",  a2_m_addr,       32'h0000_0508);
    check("full4_data_ok", a2_data_addr_ok, 32'd1);

    do_reset();

    // Ordering (DEPTH=4): D,I,D,I issued; responses alternate; pointers wrap
    @(negedge clk);
    clear_inputs();
    data_req = 1'b1; data_addr = 32'h0000_0010;
    inst_req = 1'b1; inst_addr = 32'h0000_0020; m_addr_ok = 1'b1;
    #1;
    check("ord0_m_addr",  a4_m_addr,       32'h0000_0010);
    check("ord0_data_ok", a4_data_addr_ok, 32'd1);
    @(negedge clk);
    data_req = 1'b0;
    #1;
    check("ord1_m_addr",  a4_m_addr,       32'h0000_0020);
    check("ord1_inst_ok", a4_inst_addr_ok, 32'd1);
    @(negedge clk);
    data_req = 1'b1; data_addr = 32'h0000_0030; inst_addr = 32'h0000_0040;
    #1;
    check("ord2_m_addr",  a4_m_addr,       32'h0000_0030);
    check("ord2_data_ok", a4_data_addr_ok, 32'd1);
    @(negedge clk);
    data_req = 1'b0;
    #1;
    check("ord3_m_addr",  a4_m_addr,       32'h0000_0040);
    check("ord3_inst_ok", a4_inst_addr_ok, 32'd1);
    @(negedge clk);
    inst_req = 1'b0;
    data_req = 1'b1; data_addr = 32'h0000_0050;
    m_data_ok = 1'b1; m_rdata = 32'd1;
    #1;
    check("ord_full_m_req", a4_m_req,        32'd0);
    check("ord_rsp1_data",  a4_data_data_ok, 32'd1);
    check("ord_rsp1_inst",  a4_inst_data_ok, 32'd0);
    check("ord_rsp1_rdata", a4_data_rdata,   32'd1);
    @(negedge clk);
    m_rdata = 32'd2;
    #1;
    check("ord_rsp2_inst",    a4_inst_data_ok, 32'd1);
    check("ord_rsp2_data",    a4_data_data_ok, 32'd0);
    check("ord_rsp2_issue",   a4_data_addr_ok, 32'd1);
    check("ord_rsp2_rdata",   a4_inst_rdata,   32'd2);
    @(negedge clk);
    data_req = 1'b0;
    m_rdata = 32'd3;
    #1;
    check("ord_rsp3_data", a4_data_data_ok, 32'd1);
    check("ord_rsp3_inst", a4_inst_data_ok, 32'd0);
    @(negedge clk);
    m_rdata = 32'd4;
    #1;
    check("ord_rsp4_inst", a4_inst_data_ok, 32'd1);
    check("ord_rsp4_data", a4_data_data_ok, 32'd0);
    @(negedge clk);
    m_rdata = 32'd5;
    #1;
    check("ord_rsp5_wrap_data", a4_data_data_ok, 32'd1);
    check("ord_rsp5_wrap_inst", a4_inst_data_ok, 32'd0);
    @(negedge clk);
    m_rdata = 32'd6;
    #1;
    check("ord_stray_data", a4_data_data_ok, 32'd0);
    check("ord_stray_inst", a4_inst_data_ok, 32'd0);

    do_reset();

    // Reset mid-operation: two outstanding plus a locked grant
    @(negedge clk);
    clear_inputs();
    data_req = 1'b1; data_addr = 32'h0000_0070; m_addr_ok = 1'b1;
    #1;
    check("rmo0_data_ok", a4_data_addr_ok, 32'd1);
    @(negedge clk);
    data_req = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0000_0080;
    #1;
    check("rmo1_inst_ok", a4_inst_addr_ok, 32'd1);
    @(negedge clk);
    inst_addr = 32'h0000_0090; m_addr_ok = 1'b0;
    #1;
    check("rmo2_m_req",   a4_m_req,        32'd1);
    check("rmo2_inst_ok", a4_inst_addr_ok, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rmo3_forced_m_req", a4_m_req, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    #1;
    check("rmo4_m_req_a4", a4_m_req, 32'd0);
    check("rmo4_m_req_a2", a2_m_req, 32'd0);
    @(negedge clk);
    m_data_ok = 1'b1; m_rdata = 32'd7;
    #1;
    check("rmo5_stray_inst_a4", a4_inst_data_ok, 32'd0);
    check("rmo5_stray_data_a4", a4_data_data_ok, 32'd0);
    check("rmo5_stray_data_a2", a2_data_data_ok, 32'd0);
    @(negedge clk);
    m_data_ok = 1'b0;
    inst_req = 1'b1; inst_addr = 32'h0000_00A0; m_addr_ok = 1'b1;
    #1;
    check("rmo6_m_addr",  a4_m_addr,       32'h0000_00A0);
    check("rmo6_inst_ok", a4_inst_addr_ok, 32'd1);
    @(negedge clk);
    clear_inputs();
    m_data_ok = 1'b1; m_rdata = 32'd8;
    #1;
    check("rmo7_inst_dok", a4_inst_data_ok, 32'd1);
    check("rmo7_data_dok", a4_data_data_ok, 32'd0);

    @(negedge clk);
    clear_inputs();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Two-to-one request arbiter for the CPU's single SRAM-like memory port. The instruction-fetch requester (IF stage) and the data requester (EX/MEM stage, loads and stores) share one downstream port through this block. It applies fixed data-over-instruction priority and holds a grant stable until the downstream accepts it. It records the source of every outstanding request in an in-order tag FIFO and routes each downstream response back to the requester that issued it. The block sits between the pipeline stages and the SRAM-to-AXI bridge.

## Interface
- DEPTH, 2: maximum number of outstanding (accepted, unanswered) requests; a power of 2, ≥2.
- clk  in  1  single clock; all state updates on the posedge.
- reset  in  1  synchronous, active-high reset.
- inst_req  in  1  fetch request valid; read only.
- inst_size  in  2  access size (0=byte, 1=half, 2=word).
- inst_addr  in  32  fetch address.
- inst_addr_ok  out  1  fetch request accepted this cycle.
- inst_data_ok  out  1  fetch response valid this cycle.
- inst_rdata  out  32  fetch read data.
- data_req  in  1  data request valid.
- data_wr  in  1  1=store, 0=load.
- data_size  in  2  access size.
- data_addr  in  32  data address.
- data_wstrb  in  4  byte strobes for stores.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  data request accepted this cycle.
- data_data_ok  out  1  data response valid (load data, or store completion).
- data_rdata  out  32  load data.
- m_req, m_wr  out  1 each  downstream request valid and write flag.
- m_size  out  2  downstream access size.
- m_addr  out  32  downstream address.
- m_wstrb  out  4  downstream byte strobes.
- m_wdata  out  32  downstream store data.
- m_addr_ok  in  1  downstream accepted the request.
- m_data_ok  in  1  downstream response valid; responses return in request order.
- m_rdata  in  32  downstream read data.

## Operation
- **State**
  - grant register: NONE / INST / DATA.
  - tag FIFO of DEPTH 1-bit entries: 1 = data, 0 = inst.
  - occupancy count, 0..DEPTH, with log2(DEPTH)+1 bits.
  - read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH.
- **Selection**
  - can_issue = (count < DEPTH), using the registered count.
  - When grant = NONE: select data if data_req, else inst if inst_req, else nothing. Nothing is selected when can_issue = 0.
  - When grant = INST or DATA: the locked source is selected unconditionally.
- **Downstream request**
  - m_req = 1 whenever a source is selected.
  - m_wr, m_size, m_addr, m_wstrb and m_wdata are muxed combinationally from the selected source.
  - For inst, m_wr = 0, m_wstrb = 0 and m_wdata = 0.
- **Accept**
  - Accept = m_req & m_addr_ok.
  - xxx_addr_ok = m_addr_ok & (selected == xxx); the other requester's addr_ok is 0.
  - On accept, push the tag and set grant ← NONE.
- **Lock**
  - If m_req & ~m_addr_ok, grant ← the selected source.
  - The grant stays locked until accept, even if a higher-priority request arrives. This keeps the downstream request stable.
- **Response**
  - On m_data_ok with count > 0, pop the head tag.
  - Pulse data_data_ok if the tag is 1, otherwise pulse inst_data_ok. The pulse occurs in the same cycle.
  - inst_rdata = data_rdata = m_rdata (broadcast).
  - m_data_ok with count = 0 is ignored: no pulse, no pointer change.
- **Simultaneous push and pop** leave count unchanged; both pointers advance.
- **Overflow cannot occur.** Pushes happen only when count < DEPTH, and count cannot rise while grant is locked.
- **Reset** (synchronous, highest priority): grant ← NONE, count ← 0, pointers ← 0. Requests outstanding at reset are forgotten.

## Timing
- While reset = 1, all outputs are forced to 0.
- After reset, with no requests: m_req = 0 and all ok outputs = 0.
- Request path latency is 0 cycles: m_req and xxx_addr_ok are combinational from xxx_req and m_addr_ok.
- Response path latency is 0 cycles: xxx_data_ok is combinational from m_data_ok and the FIFO head.
- Back-to-back: one accept per cycle is sustained while count < DEPTH.
- Full: with count = DEPTH, m_req = 0. Issue resumes the cycle after a pop, because can_issue uses the registered count.
- A requester must hold its request and fields stable until its addr_ok. The block relies on this and does not register request fields.

## Test plan
- **Single fetch:** inst_req=1, inst_addr=0x1C000000, m_addr_ok=1 → same cycle m_req=1, m_addr=0x1C000000, inst_addr_ok=1. Next cycle m_data_ok=1, m_rdata=0x12345678 → inst_data_ok=1, inst_rdata=0x12345678, data_data_ok=0.
- **Priority:** inst_req and data_req (store, addr 0x100, wstrb 0xF, wdata 0xDEADBEEF) both asserted, m_addr_ok=1 → cycle 0 m_wr=1, m_addr=0x100, data_addr_ok=1. Cycle 1 m_addr=inst_addr, inst_addr_ok=1. Responses then route data first, then inst.
- **Lock:** inst_req alone with m_addr_ok=0 for 3 cycles; data_req rises in cycle 1 → m_addr stays inst_addr through cycle 3 and data_addr_ok=0. Cycle 3 m_addr_ok=1 → inst_addr_ok=1. Cycle 4: data is issued.
- **Full (DEPTH=2):** two loads accepted, no m_data_ok → third request sees m_req=0. One m_data_ok → m_req=1 the following cycle.
- **Ordering (DEPTH=4):** issue data, inst, data, inst, then four m_data_ok pulses with rdata 1, 2, 3, 4 → data_data_ok on pulses 1 and 3, inst_data_ok on pulses 2 and 4. Push and pop in the same cycle keep count constant; the pointers wrap past index 3.
- **Reset mid-operation:** two requests outstanding plus a locked grant, then reset for 1 cycle → count=0 and m_req=0 with no requests present. A subsequent stray m_data_ok produces no data_ok pulse.
